comms_tx_scheduler: RTL and testbench
=====================================

// Module: comms_tx_scheduler
// PURPOSE
//  Shares one comms_processor data-plane transmit path between NUM_REQ local requesters (GPP threads/DMA ports).
//  Round-robin arbitration picks one requester and waits until the comms processor reports the transmitter ready (gpp_trf_cp).
//  It then streams the requester's words into the DP TX RAM via gpp_trf_dp/gpp_tx_data.
//  It holds the grant until the comms processor reports completion or a timeout expires.
//  Sits between the requesters and comms_processor.
// PARAMETERS
//  NUM_REQ  4    number of requesters (2..8)
//  DATA_W   16   word width, matches gpp_tx_data
//  LEN_W    8    message length field width (words, 0..2^LEN_W-1)
//  TIMEOUT  1023 max cycles allowed in WAIT_RDY or WAIT_DONE before abort
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous, active-high reset
//  req          in   NUM_REQ         level: requester i has a message pending
//  req_len      in   NUM_REQ*LEN_W   word count of requester i's message, slice i = [i*LEN_W +: LEN_W]
//  req_data     in   NUM_REQ*DATA_W  current head word of requester i (first-word-fall-through)
//  grant        out  NUM_REQ         one-hot, active while requester owns the path
//  word_ack     out  NUM_REQ         pulse: head word of requester i consumed, present next word next cycle
//  done         out  NUM_REQ         1-cycle pulse: message of requester i transmitted
//  err          out  NUM_REQ         1-cycle pulse: message of requester i aborted on timeout
//  busy         out  1               state != IDLE
//  gpp_trf_cp   in   1               comms processor: DP TX RAM may be written
//  tx_done      in   1               comms processor: 1-cycle pulse, DP transmission complete
//  gpp_trf_dp   out  1               write strobe, one word into DP TX RAM
//  gpp_tx_data  out  DATA_W          word written when gpp_trf_dp=1
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, word_ack=0, done=0, err=0, busy=0, gpp_trf_dp=0, gpp_tx_data=0.
//  Reset also sets ptr (last granted) = NUM_REQ-1, so requester 0 has first priority.
//  Reset mid-message aborts it silently: no done or err pulse.
//  FSM states: IDLE, WAIT_RDY, XFER, WAIT_DONE. All transitions occur on the clk edge.
//  IDLE:
//   - Winner = first i with req[i]=1, searching ptr+1, ptr+2, ... with wrap mod NUM_REQ.
//   - Latch the winner's index and req_len. Set grant one-hot and ptr=winner. Next state WAIT_RDY.
//   - Latched len=0: skip the transfer, pulse done[i] next cycle, return to IDLE.
//  WAIT_RDY: gpp_trf_cp=1 -> XFER, timer cleared.
//  XFER (Mealy on gpp_trf_cp):
//   - When gpp_trf_cp=1: gpp_trf_dp=1, gpp_tx_data=req_data slice of winner, word_ack[winner]=1 in the same cycle; cnt++.
//   - When gpp_trf_cp=0: no strobe, no ack, cnt held (pause, no timeout in XFER).
//   - After the strobe with cnt==len-1 -> WAIT_DONE.
//   - gpp_tx_data=0 whenever gpp_trf_dp=0.
//  WAIT_DONE: tx_done=1 -> pulse done[winner] next cycle, grant=0, IDLE.
//  Timer (width clog2(TIMEOUT+1)):
//   - Counts each cycle in WAIT_RDY or WAIT_DONE and clears on state entry.
//   - Reaching TIMEOUT: pulse err[winner], grant=0, go to IDLE. Partial words are not retransmitted.
//  tx_done outside WAIT_DONE is ignored. tx_done and timer expiry in the same cycle: done wins.
//  Latched len and index are fixed for the whole message: req or req_len changes after grant are ignored.
//   The requester holds req until done/err.
//  done/err pulse in the IDLE cycle that follows release. That same cycle may arbitrate the next winner.
//   Back-to-back messages are therefore possible with no gap cycle.
//  Fairness: a requester waits for at most NUM_REQ-1 other messages.
//  grant, word_ack, done and err are each one-hot or zero at all times.
// TESTING
//  T1 reset: assert rst with req=4'b1111 mid-XFER -> next cycle all outputs 0, busy=0.
//   After release requester 0 wins, no done/err seen.
//  T2 single msg: req[2]=1, len=3, gpp_trf_cp=1, data D0..D2 -> 3 consecutive gpp_trf_dp strobes carrying D0,D1,D2.
//   Then word_ack[2] x3; tx_done -> done[2] pulse, grant=0.
//  T3 round robin: req=4'b1011 held, each message len=1 with tx_done 2 cycles later -> grant order 0,1,3,0,1.
//  T4 backpressure: len=4, gpp_trf_cp drops after word 2 for 5 cycles -> no strobes or acks during the gap.
//   Words 3,4 follow when it returns, data order preserved.
//  T5 timeout: TIMEOUT=15, gpp_trf_cp held 0 -> err[winner] pulse exactly 15 cycles after WAIT_RDY entry.
//   Grant released, next requester served.
//  T6 zero length: req[1]=1, len=0 -> no gpp_trf_dp, done[1] pulse within 2 cycles.
//   tx_done together with timer expiry -> done only.

Source files
------------

// File: rtl/comms_tx_scheduler.sv
// comms_tx_scheduler
// Round-robin scheduler that lets NUM_REQ requesters share a single
// comms_processor DP transmit path. It owns the path from the grant until
// tx_done arrives or the ready/done timer expires.
module comms_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        word_ack,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    input  logic                      gpp_trf_cp,
    input  logic                      tx_done,
    output logic                      gpp_trf_dp,
    output logic [DATA_W-1:0]         gpp_tx_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RDY  = 2'd1,
        XFER      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [LEN_W-1:0]   len, len_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [NUM_REQ-1:0] done_q, done_n;
    logic [NUM_REQ-1:0] err_q, err_n;

    logic [NUM_REQ-1:0] req_avail;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [LEN_W-1:0]   win_len;
    logic               timer_exp;
    logic               strobe;
    int                 arb_j;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // A requester still shows req in the cycle its done/err pulses, so it is
    // masked out of that cycle's arbitration to avoid being served twice.
    assign req_avail = req & ~(done_q | err_q);
    assign timer_exp = (timer == TMR_W'(TIMEOUT - 1));

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_j = int'(ptr) + k;
            if (arb_j >= NUM_REQ) begin
                arb_j = arb_j - NUM_REQ;
            end
            if (!win_found && req_avail[IDX_W'(arb_j)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(arb_j);
            end
        end
    end

    assign win_len = req_len[win_idx*LEN_W +: LEN_W];

    // Next-state logic; the XFER strobe follows gpp_trf_cp combinationally.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx;
        len_n   = len;
        cnt_n   = cnt;
        done_n  = '0;
        err_n   = '0;
        strobe  = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    ptr_n = win_idx;
                    idx_n = win_idx;
                    len_n = win_len;
                    cnt_n = '0;
                    if (win_len == '0) begin
                        done_n = onehot(win_idx);
                    end else begin
                        state_n = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (gpp_trf_cp) begin
                    state_n = XFER;
                end else if (timer_exp) begin
                    err_n   = onehot(idx);
                    state_n = IDLE;
                end
            end
            XFER: begin
                if (gpp_trf_cp) begin
                    strobe = 1'b1;
                    cnt_n  = cnt + LEN_W'(1);
                    if (cnt == len - LEN_W'(1)) begin
                        state_n = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    done_n  = onehot(idx);
                    state_n = IDLE;
                end else if (timer_exp) begin
                    err_n   = onehot(idx);
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Timer runs only while staying in a wait state; any state change clears it.
    always_comb begin
        timer_n = '0;
        if ((state_n == state) && ((state == WAIT_RDY) || (state == WAIT_DONE))) begin
            timer_n = timer + TMR_W'(1);
        end
    end

    // State register; reset drops any message in flight without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= IDX_W'(NUM_REQ - 1);
            idx    <= '0;
            len    <= '0;
            cnt    <= '0;
            timer  <= '0;
            done_q <= '0;
            err_q  <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            idx    <= idx_n;
            len    <= len_n;
            cnt    <= cnt_n;
            timer  <= timer_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign busy        = (state != IDLE);
    assign grant       = busy ? onehot(idx) : '0;
    assign word_ack    = strobe ? onehot(idx) : '0;
    assign gpp_trf_dp  = strobe;
    assign gpp_tx_data = strobe ? req_data[idx*DATA_W +: DATA_W] : '0;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_comms_tx_scheduler.sv
// tb_comms_tx_scheduler
// Directed bench for comms_tx_scheduler with NUM_REQ=4 and TIMEOUT=15.
module tb_comms_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 15;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        word_ack;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic                      busy;
    logic                      gpp_trf_cp;
    logic                      tx_done;
    logic                      gpp_trf_dp;
    logic [DATA_W-1:0]         gpp_tx_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] wptr [NUM_REQ];

    comms_tx_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_len     (req_len),
        .req_data    (req_data),
        .grant       (grant),
        .word_ack    (word_ack),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .gpp_trf_cp  (gpp_trf_cp),
        .tx_done     (tx_done),
        .gpp_trf_dp  (gpp_trf_dp),
        .gpp_tx_data (gpp_tx_data)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input int r, input int n);
        return 16'hA000 + 16'(r * 256) + 16'(n);
    endfunction

    // Requester model: first-word-fall-through queue advanced by word_ack.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst || done[i] || err[i]) begin
                wptr[i] <= 8'd0;
            end else if (word_ack[i]) begin
                wptr[i] <= wptr[i] + 8'd1;
            end
        end
    end

    // Present each requester's current head word.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = word_of(i, int'(wptr[i]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int r, input int l);
        req_len[r*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        req_len    = '0;
        gpp_trf_cp = 1'b0;
        tx_done    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant, word_ack, done, err, busy, gpp_trf_dp} !== '0 || gpp_tx_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got grant=%b ack=%b done=%b err=%b busy=%b dp=%b data=%h want all 0",
                     grant, word_ack, done, err, busy, gpp_trf_dp, gpp_tx_data);
        end
        req        = 4'b1111;
        set_len(0, 4); set_len(1, 4); set_len(2, 4); set_len(3, 4);
        gpp_trf_cp = 1'b1;
        step();
        step();
        step();
        checks++;
        if (gpp_trf_dp !== 1'b1 || grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_midxfer got dp=%b grant=%b want dp=1 grant=0001", gpp_trf_dp, grant);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({grant, word_ack, done, err, busy, gpp_trf_dp} !== '0 || gpp_tx_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_abort got grant=%b ack=%b done=%b err=%b busy=%b dp=%b want all 0",
                     grant, word_ack, done, err, busy, gpp_trf_dp);
        end
        rst = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0001 || done !== '0 || err !== '0) begin
            errors++;
            $display("[TB] FAIL reset_first_winner got grant=%b done=%b err=%b want grant=0001 done=0 err=0",
                     grant, done, err);
        end
        do_reset();
    endtask

    task automatic test_single_message();
        req        = 4'b0100;
        set_len(2, 3);
        gpp_trf_cp = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b1 || gpp_trf_dp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_grant got grant=%b busy=%b dp=%b want 0100 1 0", grant, busy, gpp_trf_dp);
        end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (gpp_trf_dp !== 1'b1 || gpp_tx_data !== word_of(2, n) || word_ack !== 4'b0100) begin
                errors++;
                $display("[TB] FAIL single_word%0d got dp=%b data=%h ack=%b want 1 %h 0100",
                         n, gpp_trf_dp, gpp_tx_data, word_ack, word_of(2, n));
            end
        end
        step();
        checks++;
        if (gpp_trf_dp !== 1'b0 || gpp_tx_data !== '0 || word_ack !== '0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_wait_done got dp=%b data=%h ack=%b busy=%b want 0 0000 0000 1",
                     gpp_trf_dp, gpp_tx_data, word_ack, busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0100 || grant !== '0 || err !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done got done=%b grant=%b err=%b busy=%b want 0100 0000 0000 0",
                     done, grant, err, busy);
        end
        req = '0;
        step();
        checks++;
        if (done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done_pulse got done=%b busy=%b want 0000 0", done, busy);
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        order = '{0, 1, 3, 0, 1};
        do_reset();
        req        = 4'b1011;
        set_len(0, 1); set_len(1, 1); set_len(3, 1);
        gpp_trf_cp = 1'b1;
        for (int m = 0; m < 5; m++) begin
            step();
            checks++;
            if (grant !== (4'b0001 << order[m])) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d got %b want %b", m, grant, 4'b0001 << order[m]);
            end
            step();
            checks++;
            if (gpp_trf_dp !== 1'b1 || word_ack !== (4'b0001 << order[m])) begin
                errors++;
                $display("[TB] FAIL rr_strobe%0d got dp=%b ack=%b want 1 %b",
                         m, gpp_trf_dp, word_ack, 4'b0001 << order[m]);
            end
            step();
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++;
            if (done !== (4'b0001 << order[m]) || grant !== '0) begin
                errors++;
                $display("[TB] FAIL rr_done%0d got done=%b grant=%b want %b 0000",
                         m, done, grant, 4'b0001 << order[m]);
            end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_backpressure();
        req        = 4'b0001;
        set_len(0, 4);
        gpp_trf_cp = 1'b1;
        step();
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (gpp_trf_dp !== 1'b1 || gpp_tx_data !== word_of(0, n)) begin
                errors++;
                $display("[TB] FAIL bp_word%0d got dp=%b data=%h want 1 %h", n, gpp_trf_dp, gpp_tx_data, word_of(0, n));
            end
        end
        for (int g = 0; g < 5; g++) begin
            step();
            gpp_trf_cp = 1'b0;
            #1;
            checks++;
            if (gpp_trf_dp !== 1'b0 || word_ack !== '0 || gpp_tx_data !== '0 || grant !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL bp_gap%0d got dp=%b ack=%b data=%h grant=%b want 0 0000 0000 0001",
                         g, gpp_trf_dp, word_ack, gpp_tx_data, grant);
            end
        end
        for (int n = 2; n < 4; n++) begin
            step();
            gpp_trf_cp = 1'b1;
            #1;
            checks++;
            if (gpp_trf_dp !== 1'b1 || gpp_tx_data !== word_of(0, n) || word_ack !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL bp_word%0d got dp=%b data=%h ack=%b want 1 %h 0001",
                         n, gpp_trf_dp, gpp_tx_data, word_ack, word_of(0, n));
            end
        end
        step();
        checks++;
        if (gpp_trf_dp !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_end got dp=%b busy=%b want 0 1", gpp_trf_dp, busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_done got %b want 0001", done);
        end
        req = '0;
        step();
    endtask

    task automatic test_timeout();
        req        = 4'b1100;
        set_len(2, 2);
        set_len(3, 1);
        gpp_trf_cp = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL to_grant got %b want 0100", grant);
        end
        for (int n = 1; n < TIMEOUT; n++) begin
            step();
            checks++;
            if (err !== '0 || grant !== 4'b0100) begin
                errors++;
                $display("[TB] FAIL to_early%0d got err=%b grant=%b want 0000 0100", n, err, grant);
            end
        end
        step();
        checks++;
        if (err !== 4'b0100 || grant !== '0 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_err got err=%b grant=%b done=%b busy=%b want 0100 0000 0000 0",
                     err, grant, done, busy);
        end
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000 || err !== '0) begin
            errors++;
            $display("[TB] FAIL to_next_grant got grant=%b err=%b want 1000 0000", grant, err);
        end
        gpp_trf_cp = 1'b1;
        step();
        checks++;
        if (gpp_trf_dp !== 1'b1 || gpp_tx_data !== word_of(3, 0)) begin
            errors++;
            $display("[TB] FAIL to_next_word got dp=%b data=%h want 1 %h", gpp_trf_dp, gpp_tx_data, word_of(3, 0));
        end
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL to_next_done got %b want 1000", done);
        end
        req = '0;
        step();
    endtask

    task automatic test_zero_length();
        req        = 4'b0010;
        set_len(1, 0);
        gpp_trf_cp = 1'b1;
        #1;
        checks++;
        if (gpp_trf_dp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zl_no_strobe got dp=%b want 0", gpp_trf_dp);
        end
        step();
        checks++;
        if (done !== 4'b0010 || gpp_trf_dp !== 1'b0 || grant !== '0 || err !== '0) begin
            errors++;
            $display("[TB] FAIL zl_done got done=%b dp=%b grant=%b err=%b want 0010 0 0000 0000",
                     done, gpp_trf_dp, grant, err);
        end
        req = '0;
        step();
        checks++;
        if (done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zl_single_pulse got done=%b busy=%b want 0000 0", done, busy);
        end
        req = 4'b0010;
        set_len(1, 1);
        step();
        step();
        step();
        gpp_trf_cp = 1'b0;
        repeat (TIMEOUT - 1) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0010 || err !== '0) begin
            errors++;
            $display("[TB] FAIL tie_done_wins got done=%b err=%b want 0010 0000", done, err);
        end
        req = '0;
        step();
        checks++;
        if (err !== '0 || done !== '0) begin
            errors++;
            $display("[TB] FAIL tie_no_late_err got err=%b done=%b want 0000 0000", err, done);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_len    = '0;
        gpp_trf_cp = 1'b0;
        tx_done    = 1'b0;
        test_reset();
        test_single_message();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_zero_length();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
